// File: rtl/fp_byte_stream_loader.sv
// Byte-serial operand loader and result drainer for the 32-bit FP ALU core.
// Optional result-wait watchdog enabled by defining FP_TIMEOUT_EN.
module fp_byte_stream_loader #(
    parameter int WIDTH          = 32,
    parameter int OPW            = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             flush,
    input  logic [7:0]       byte_in,
    input  logic             byte_stb,
    input  logic [OPW-1:0]   op_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   op_code,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [WIDTH-1:0] res_in,
    input  logic             res_valid,
    output logic [7:0]       byte_out,
    output logic             byte_out_valid,
    input  logic             byte_ack,
    output logic             busy,
    output logic             timeout
);
    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a positive multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_sh;
    logic             last_byte;
    logic             ack_take;
    logic             expire;

    assign last_byte = (cnt == CW'(NB - 1));
    assign ack_take  = byte_ack && byte_out_valid;
    assign byte_out  = res_sh[7:0];
    assign busy      = (state == ISSUE) || (state == WAIT_RES) || (state == DRAIN);

`ifdef FP_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tcnt;

    assign expire = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside WAIT_RES, so every entry starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                tcnt    <= '0;
                timeout <= 1'b0;
            end else if (state != WAIT_RES) begin
                tcnt <= '0;
            end else if (!res_valid) begin
                if (expire) timeout <= 1'b1;
                else        tcnt    <= tcnt + 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_A;
        else if (ena) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD_A:   if (byte_stb && last_byte) state_nx = LOAD_B;
            LOAD_B:   if (byte_stb && last_byte) state_nx = ISSUE;
            ISSUE:    if (op_ready) state_nx = WAIT_RES;
            WAIT_RES: if (res_valid || expire) state_nx = DRAIN;
            DRAIN:    if (ack_take && last_byte) state_nx = LOAD_A;
            default:  state_nx = LOAD_A;
        endcase
        if (flush) state_nx = LOAD_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            op_a           <= '0;
            op_b           <= '0;
            op_code        <= '0;
            op_valid       <= 1'b0;
            res_sh         <= '0;
            byte_out_valid <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                cnt            <= '0;
                op_valid       <= 1'b0;
                res_sh         <= '0;
                byte_out_valid <= 1'b0;
            end else begin
                case (state)
                    LOAD_A: if (byte_stb) begin
                        op_a[8*cnt +: 8] <= byte_in;
                        cnt              <= last_byte ? '0 : cnt + 1'b1;
                    end
                    LOAD_B: if (byte_stb) begin
                        op_b[8*cnt +: 8] <= byte_in;
                        cnt              <= last_byte ? '0 : cnt + 1'b1;
                        if (last_byte) begin
                            op_code  <= op_in;
                            op_valid <= 1'b1;
                        end
                    end
                    ISSUE: if (op_ready) op_valid <= 1'b0;
                    WAIT_RES: begin
                        // A real result beats a same-cycle watchdog expiry.
                        if (res_valid) begin
                            res_sh         <= res_in;
                            byte_out_valid <= 1'b1;
                        end else if (expire) begin
                            res_sh         <= WIDTH'(32'h7FC0_0000);
                            byte_out_valid <= 1'b1;
                        end
                    end
                    DRAIN: if (ack_take) begin
                        res_sh <= res_sh >> 8;
                        cnt    <= last_byte ? '0 : cnt + 1'b1;
                        if (last_byte) byte_out_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_byte_stream_loader.sv
// Self-checking bench for fp_byte_stream_loader: directed scenarios plus
// randomized transactions checked against a word-level reference model.
module tb_fp_byte_stream_loader;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_stb = 1'b0;
    logic [2:0]  op_in = '0;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_code;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] res_in = '0;
    logic        res_valid = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        byte_ack = 1'b0;
    logic        busy;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    fp_byte_stream_loader #(.WIDTH(32), .OPW(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
        .byte_in(byte_in), .byte_stb(byte_stb), .op_in(op_in),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .op_valid(op_valid),
        .op_ready(op_ready), .res_in(res_in), .res_valid(res_valid),
        .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_ack(byte_ack),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [2:0] op);
        byte_in  = b;
        op_in    = op;
        byte_stb = 1'b1;
        tick();
        byte_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({op_a, op_b, op_code, op_valid, byte_out, byte_out_valid, busy, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%0d v=%b bo=%h bov=%b busy=%b to=%b, want all zero",
                     op_a, op_b, op_code, op_valid, byte_out, byte_out_valid, busy, timeout);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_issue();
        logic [31:0] a = 32'h3F80_0000;
        logic [31:0] b = 32'h4000_0000;
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 3'd0);
        for (int i = 0; i < 3; i++) send_byte(b[8*i +: 8], 3'd0);
        checks++;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL issue_early: op_valid=%b want 0", op_valid); end
        send_byte(b[31:24], 3'd1);
        checks++;
        if ({op_valid, busy, op_a, op_b, op_code} !== {1'b1, 1'b1, a, b, 3'd1}) begin
            errors++;
            $display("FAIL issue_first: v=%b busy=%b a=%h b=%h op=%0d want v=1 busy=1 a=%h b=%h op=1",
                     op_valid, busy, op_a, op_b, op_code, a, b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({op_valid, op_a, op_b, op_code} !== {1'b1, a, b, 3'd1}) begin
                errors++;
                $display("FAIL issue_hold: v=%b a=%h b=%h op=%0d want held", op_valid, op_a, op_b, op_code);
            end
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        checks++;
        if ({op_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL issue_accept: v=%b busy=%b want v=0 busy=1", op_valid, busy);
        end
    endtask

    task automatic test_drain();
        logic [31:0] r = 32'h4040_0000;
        res_in = r; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({byte_out_valid, byte_out} !== {1'b1, r[8*i +: 8]}) begin
                errors++;
                $display("FAIL drain_byte%0d: bov=%b bo=%h want bov=1 bo=%h", i, byte_out_valid, byte_out, r[8*i +: 8]);
            end
            byte_ack = 1'b1;
            tick();
            byte_ack = 1'b0;
        end
        checks++;
        if ({byte_out_valid, byte_out, busy} !== 10'd0) begin
            errors++;
            $display("FAIL drain_end: bov=%b bo=%h busy=%b want all 0", byte_out_valid, byte_out, busy);
        end
        res_valid = 1'b1; byte_ack = 1'b1;
        tick();
        res_valid = 1'b0; byte_ack = 1'b0;
        checks++;
        if ({byte_out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL res_in_idle: bov=%b busy=%b want 0 0", byte_out_valid, busy);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] a = 32'h3F80_0000;
        logic [31:0] b = 32'h4000_0000;
        logic [63:0] bytes = {b, a};
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 3)) tick();
            if (i == 7) begin
                checks++;
                if (op_valid !== 1'b0) begin errors++; $display("FAIL gaps_early: op_valid=%b want 0", op_valid); end
            end
            send_byte(bytes[8*i +: 8], (i == 7) ? 3'd1 : 3'd6);
        end
        checks++;
        if ({op_valid, op_a, op_b, op_code} !== {1'b1, a, b, 3'd1}) begin
            errors++;
            $display("FAIL gaps_issue: v=%b a=%h b=%h op=%0d want v=1 a=%h b=%h op=1", op_valid, op_a, op_b, op_code, a, b);
        end
        op_ready = 1'b1; tick(); op_ready = 1'b0;
        res_in = 32'h1234_5678; res_valid = 1'b1; tick(); res_valid = 1'b0;
        byte_ack = 1'b1; repeat (4) tick(); byte_ack = 1'b0;
        checks++;
        if ({busy, byte_out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL gaps_return: busy=%b bov=%b want 0 0", busy, byte_out_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 3'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++;
        if ({op_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_state: v=%b busy=%b want 0 0", op_valid, busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checks++;
                if (op_valid !== 1'b0) begin errors++; $display("FAIL flush_early: op_valid=%b want 0", op_valid); end
            end
            send_byte(8'h11 + 8'(i), 3'd5);
        end
        checks++;
        if ({op_valid, op_a, op_b, op_code} !== {1'b1, 32'h1413_1211, 32'h1817_1615, 3'd5}) begin
            errors++;
            $display("FAIL flush_reload: v=%b a=%h b=%h op=%0d want v=1 a=14131211 b=18171615 op=5",
                     op_valid, op_a, op_b, op_code);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++;
        if ({op_valid, busy, op_a} !== {2'b00, 32'h1413_1211}) begin
            errors++;
            $display("FAIL flush_issue: v=%b busy=%b a=%h want v=0 busy=0 a=14131211", op_valid, busy, op_a);
        end
    endtask

    task automatic test_ena_hold();
        logic [31:0] r = $urandom;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 3'd2);
        op_ready = 1'b1; tick(); op_ready = 1'b0;
        res_in = r; res_valid = 1'b1; tick(); res_valid = 1'b0;
        byte_ack = 1'b1; tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({byte_out_valid, byte_out} !== {1'b1, r[15:8]}) begin
                errors++;
                $display("FAIL ena_hold%0d: bov=%b bo=%h want bov=1 bo=%h", i, byte_out_valid, byte_out, r[15:8]);
            end
        end
        ena = 1'b1;
        for (int i = 2; i < 4; i++) begin
            tick();
            checks++;
            if ({byte_out_valid, byte_out} !== {1'b1, r[8*i +: 8]}) begin
                errors++;
                $display("FAIL ena_resume%0d: bov=%b bo=%h want bov=1 bo=%h", i, byte_out_valid, byte_out, r[8*i +: 8]);
            end
        end
        tick();
        byte_ack = 1'b0;
        checks++;
        if ({byte_out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ena_end: bov=%b busy=%b want 0 0", byte_out_valid, busy);
        end
    endtask

    task automatic test_wait_res();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 3'd3);
        op_ready = 1'b1; tick(); op_ready = 1'b0;
`ifdef FP_TIMEOUT_EN
        repeat (TO - 1) tick();
        checks++;
        if ({byte_out_valid, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL to_early: bov=%b to=%b want 0 0", byte_out_valid, timeout);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({byte_out_valid, timeout, byte_out} !== {2'b11, 8'(32'h7FC0_0000 >> (8*i))}) begin
                errors++;
                $display("FAIL to_byte%0d: bov=%b to=%b bo=%h want bov=1 to=1 bo=%h",
                         i, byte_out_valid, timeout, byte_out, 8'(32'h7FC0_0000 >> (8*i)));
            end
            byte_ack = 1'b1; tick(); byte_ack = 1'b0;
        end
        checks++;
        if ({timeout, busy} !== 2'b10) begin
            errors++;
            $display("FAIL to_sticky: to=%b busy=%b want 1 0", timeout, busy);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL to_flush: to=%b want 0", timeout); end
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 3'd3);
        op_ready = 1'b1; tick(); op_ready = 1'b0;
        repeat (TO - 1) tick();
        res_in = 32'hCAFE_F00D; res_valid = 1'b1; tick(); res_valid = 1'b0;
        checks++;
        if ({byte_out_valid, timeout, byte_out} !== {2'b10, 8'h0D}) begin
            errors++;
            $display("FAIL to_race: bov=%b to=%b bo=%h want bov=1 to=0 bo=0d", byte_out_valid, timeout, byte_out);
        end
`else
        repeat (300) tick();
        checks++;
        if ({busy, byte_out_valid, timeout} !== 3'b100) begin
            errors++;
            $display("FAIL wait_forever: busy=%b bov=%b to=%b want 1 0 0", busy, byte_out_valid, timeout);
        end
        res_in = 32'hCAFE_F00D; res_valid = 1'b1; tick(); res_valid = 1'b0;
        checks++;
        if ({byte_out_valid, byte_out} !== {1'b1, 8'h0D}) begin
            errors++;
            $display("FAIL wait_result: bov=%b bo=%h want 1 0d", byte_out_valid, byte_out);
        end
`endif
        byte_ack = 1'b1; repeat (4) tick(); byte_ack = 1'b0;
    endtask

    // Reference model: an operand is the little-endian concatenation of its
    // bytes; the result stream is the captured word split back into bytes.
    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            logic [7:0]  ab[8];
            logic [31:0] exp_a, exp_b, r;
            logic [2:0]  op;
            logic [7:0]  q[$];
            op = 3'($urandom);
            r  = $urandom;
            exp_a = '0; exp_b = '0;
            for (int i = 0; i < 8; i++) ab[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                exp_a = exp_a + (32'(ab[i]) << (8*i));
                exp_b = exp_b + (32'(ab[i+4]) << (8*i));
            end
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_byte(ab[i], (i == 7) ? op : 3'($urandom));
            end
            for (int d = $urandom_range(0, 3); d >= 0; d--) begin
                checks++;
                if ({op_valid, op_a, op_b, op_code} !== {1'b1, exp_a, exp_b, op}) begin
                    errors++;
                    $display("FAIL rand_issue t%0d: v=%b a=%h b=%h op=%0d want v=1 a=%h b=%h op=%0d",
                             t, op_valid, op_a, op_b, op_code, exp_a, exp_b, op);
                end
                op_ready = (d == 0);
                tick();
            end
            op_ready = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                byte_ack = 1'(($urandom));
                tick();
            end
            byte_ack = 1'b0;
            res_in = r; res_valid = 1'b1; tick(); res_valid = 1'b0;
            for (int i = 0; i < 4; i++) q.push_back(r[8*i +: 8]);
            while (q.size() > 0) begin
                repeat ($urandom_range(0, 2)) tick();
                checks++;
                if ({byte_out_valid, byte_out} !== {1'b1, q[0]}) begin
                    errors++;
                    $display("FAIL rand_byte t%0d: bov=%b bo=%h want bov=1 bo=%h", t, byte_out_valid, byte_out, q[0]);
                end
                void'(q.pop_front());
                byte_ack = 1'b1; tick(); byte_ack = 1'b0;
            end
            checks++;
            if ({busy, byte_out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rand_end t%0d: busy=%b bov=%b want 0 0", t, busy, byte_out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_issue();
        test_drain();
        test_gaps();
        test_flush();
        test_ena_hold();
        test_wait_res();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_byte_stream_loader.md
Name: fp_byte_stream_loader

Overview:
- Byte-serial front/back end for the 32-bit floating-point ALU core on the 8-bit TinyTapeout pins.
- Assembles operand A, operand B and an opcode from 8-bit input bytes, then issues them to the ALU core with a valid/ready handshake.
- Captures the core's 32-bit result and streams it back out one byte at a time.
- Sits directly upstream of the ALU core and also drains its output.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of 8. NB = WIDTH/8 bytes per word.
- OPW, 3, opcode width.
- TIMEOUT_CYCLES, 255, result wait limit. Used only with FP_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  when low, all registers hold.
- flush  input  1  synchronous abort; returns the block to LOAD_A.
- byte_in  input  8  operand byte.
- byte_stb  input  1  byte_in is valid this cycle.
- op_in  input  OPW  opcode, sampled with the last byte of B.
- op_a  output  WIDTH  operand A to the core.
- op_b  output  WIDTH  operand B to the core.
- op_code  output  OPW  opcode to the core.
- op_valid  output  1  operands valid.
- op_ready  input  1  core accepts the operands.
- res_in  input  WIDTH  core result.
- res_valid  input  1  core result valid (single-cycle pulse).
- byte_out  output  8  current result byte.
- byte_out_valid  output  1  byte_out is valid.
- byte_ack  input  1  consumer took byte_out.
- busy  output  1  high in ISSUE, WAIT_RES and DRAIN.
- timeout  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n low): all outputs and registers are 0, state = LOAD_A, byte counter = 0, timeout = 0.
- All state advances only when ena=1. Priority order: reset > flush > normal operation.
- flush=1 (with ena=1): go to LOAD_A, clear the byte counter, op_valid=0, byte_out_valid=0. op_a/op_b keep their values. timeout is cleared.
- LOAD_A:
  - Each cycle with byte_stb=1 writes byte_in into op_a[8k+7:8k], where k = counter. Byte order is little-endian: first byte goes to [7:0].
  - Cycles with byte_stb=0 are gaps; nothing changes.
  - After byte NB-1: counter returns to 0, go to LOAD_B.
- LOAD_B:
  - Same byte assembly into op_b.
  - On byte NB-1, also latch op_in into op_code, then go to ISSUE.
  - op_valid=1 on the next cycle. Latency is one cycle from the last byte accepted to op_valid.
- ISSUE:
  - Hold op_valid=1 with op_a, op_b and op_code stable until a cycle where op_ready=1.
  - Next cycle: op_valid=0, state WAIT_RES.
  - If op_ready is already high on the first ISSUE cycle, the transfer completes in that cycle.
- WAIT_RES:
  - On res_valid=1: capture res_in into the shift register and go to DRAIN.
  - Next cycle: byte_out = res[7:0] and byte_out_valid=1.
  - res_valid in any other state is ignored.
- DRAIN:
  - Each cycle with byte_ack=1 shifts the next byte out (little-endian order).
  - On ack of byte NB-1: byte_out_valid=0, byte_out=0, go to LOAD_A.
  - byte_ack while byte_out_valid=0 is ignored.
- byte_stb outside LOAD_A/LOAD_B is ignored; no buffering.
- op_a/op_b are visible while loading but are only qualified by op_valid.

Optional Feature:
- Macro: FP_TIMEOUT_EN.
- When defined:
  - An 8+-bit counter runs in WAIT_RES and clears on entry to WAIT_RES.
  - If TIMEOUT_CYCLES cycles elapse without res_valid, load WIDTH'h7FC00000 (canonical quiet NaN) into the result shift register, set timeout=1 (sticky), and go to DRAIN.
  - timeout clears only on reset or flush.
  - res_valid arriving in the same cycle as expiry wins; timeout stays 0.
- When undefined:
  - WAIT_RES waits indefinitely.
  - timeout is tied to 0.
  - No counter logic is present.

Test Plan:
1. Bytes 00,00,80,3F then 00,00,00,40 with op_in=1 on the last byte, op_ready held 0 -> op_valid=1 one cycle after the last byte, op_a=3F800000, op_b=40000000, op_code=1, all held. Raise op_ready for 1 cycle -> op_valid=0 the next cycle, busy=1.
2. In WAIT_RES, pulse res_valid with res_in=40400000 -> next cycle byte_out=00 with byte_out_valid=1. Acks return 00,40,40. After the 4th ack: byte_out_valid=0, busy=0, state LOAD_A.
3. Same 8 bytes as test 1, with byte_stb gaps of 1-3 idle cycles between bytes -> identical op_a/op_b/op_valid timing relative to the last strobe.
4. Assert flush after 2 bytes of B, then send 8 fresh bytes 11..18 -> op_a=14131211, op_b=18171615. No earlier op_valid.
5. In DRAIN with byte_ack=1 and ena=0 for 3 cycles -> byte_out is unchanged and no byte is lost. Re-enable -> the sequence continues.
6. FP_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no res_valid -> after 4 WAIT_RES cycles, bytes 00,00,C0,7F are streamed and timeout=1 until flush.
